// File: rtl/mem_arbiter_pkg.sv
// Shared pipeline definitions: arbiter state encoding, data-run default,
// run-counter sizing helper and the RV32I major opcode constants.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_e;

    // Data grants allowed back-to-back while a fetch is waiting.
    localparam int unsigned DEFAULT_MAX_DATA_RUN = 4;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Bits needed to hold 0..max_run; never narrower than one bit.
    function automatic int unsigned run_cnt_width(input int unsigned max_run);
        return (max_run < 1) ? 1 : $clog2(max_run + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// Grant priority: data wins a tie unless the data run has reached its limit,
// in which case the waiting fetch is served.
module arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_RUN = DEFAULT_MAX_DATA_RUN,
    parameter int unsigned CNT_W        = run_cnt_width(MAX_DATA_RUN)
) (
    input  logic             data_req_i,
    input  logic             fetch_req_i,
    input  logic [CNT_W-1:0] run_cnt_i,
    output logic             grant_data_o,
    output logic             grant_fetch_o
);

    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_DATA_RUN);

    logic starved;

    // Fetch is starved once the run counter sits at its limit with a fetch waiting.
    always_comb begin
        starved       = fetch_req_i && (run_cnt_i == RUN_MAX);
        grant_data_o  = data_req_i && !starved;
        grant_fetch_o = fetch_req_i && !grant_data_o;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// One transaction in flight; an IDLE cycle separates consecutive grants.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_RUN = DEFAULT_MAX_DATA_RUN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        IF_flush,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        m_valid,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        if_stall,
    output logic        mem_stall
);

    localparam int unsigned      CNT_W   = run_cnt_width(MAX_DATA_RUN);
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_DATA_RUN);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             drop_q, drop_d;
    logic             m_we_q, m_we_d;
    logic [31:0]      m_addr_q, m_addr_d;
    logic [31:0]      m_wdata_q, m_wdata_d;

    logic data_req, fetch_req, grant_data, grant_fetch;
    logic in_idle, in_fetch, in_data, drop_now;

    assign data_req  = mem_read | mem_write;
    assign fetch_req = if_req & ~IF_flush;
    assign in_idle   = (state_q == IDLE);
    assign in_fetch  = (state_q == FETCH);
    assign in_data   = (state_q == DATA);
    // A flush in the current FETCH cycle already cancels delivery.
    assign drop_now  = drop_q | (in_fetch & IF_flush);

    arb_prio #(
        .MAX_DATA_RUN (MAX_DATA_RUN),
        .CNT_W        (CNT_W)
    ) u_arb_prio (
        .data_req_i    (data_req),
        .fetch_req_i   (fetch_req),
        .run_cnt_i     (run_cnt_q),
        .grant_data_o  (grant_data),
        .grant_fetch_o (grant_fetch)
    );

    // Next-state, request capture at grant, drop flag and data-run counter.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        drop_d    = drop_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        run_cnt_d = run_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d   = DATA;
                    m_addr_d  = dm_addr;
                    m_we_d    = mem_write;
                    m_wdata_d = dm_wdata;
                end else if (grant_fetch) begin
                    state_d   = FETCH;
                    m_addr_d  = if_addr;
                    m_we_d    = 1'b0;
                    m_wdata_d = '0;
                end
            end
            FETCH: begin
                drop_d = drop_now;
                if (m_ready) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end
            end
            DATA: begin
                if (m_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The run only counts data grants made while a fetch is being held off.
        if (!if_req || (in_idle && grant_fetch)) begin
            run_cnt_d = '0;
        end else if (in_idle && grant_data && (run_cnt_q != RUN_MAX)) begin
            run_cnt_d = run_cnt_q + CNT_W'(1);
        end
    end

    // State and captured request registers; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: only control state and the few request registers exist here, so all are reset.
            state_q   <= IDLE;
            run_cnt_q <= '0;
            drop_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            drop_q    <= drop_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    assign m_valid   = in_fetch | in_data;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;

    assign dm_ready  = in_data & m_ready;
    assign dm_rdata  = m_rdata;
    assign if_ready  = in_fetch & m_ready & ~drop_now;
    assign if_rdata  = m_rdata;

    assign if_stall  = if_req & ~if_ready;
    assign mem_stall = data_req & ~dm_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized phase, all compared against a transaction-level model.
module tb_mem_arbiter;

    localparam int MAX_RUN = 4;

    logic        clk, rst_n;
    logic        if_req, IF_flush, mem_read, mem_write, m_ready;
    logic [31:0] if_addr, dm_addr, dm_wdata, m_rdata;
    logic [31:0] if_rdata, dm_rdata, m_addr, m_wdata;
    logic        if_ready, dm_ready, m_valid, m_we, if_stall, mem_stall;

    mem_arbiter #(.MAX_DATA_RUN(MAX_RUN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .IF_flush  (IF_flush),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .m_valid   (m_valid),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_ready   (m_ready),
        .if_stall  (if_stall),
        .mem_stall (mem_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference: at most one memory transaction outstanding.
    typedef struct {
        bit          busy;
        bit          is_data;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        bit          drop;
    } txn_t;

    txn_t cur;
    int   run;

    // Observations of the DUT used by directed scenarios.
    logic [31:0] dut_grants[$];
    bit          prev_valid;
    int          if_pulses, dm_pulses;
    bit          last_if_ready, last_dm_ready;

    task automatic model_reset();
        cur.busy = 0; cur.is_data = 0; cur.addr = '0;
        cur.we = 0; cur.wdata = '0; cur.drop = 0;
        run = 0;
    endtask

    // Apply one rising edge to the model using the inputs currently driven.
    task automatic model_edge();
        bit dreq, freq;
        if (!rst_n) return;
        if (!cur.busy) begin
            dreq = mem_read || mem_write;
            freq = if_req && !IF_flush;
            if (dreq && !(freq && run == MAX_RUN)) begin
                cur.busy = 1; cur.is_data = 1; cur.addr = dm_addr;
                cur.we = mem_write; cur.wdata = dm_wdata; cur.drop = 0;
                if (!if_req) run = 0;
                else if (run < MAX_RUN) run = run + 1;
            end else if (freq) begin
                cur.busy = 1; cur.is_data = 0; cur.addr = if_addr;
                cur.we = 0; cur.wdata = '0; cur.drop = 0;
                run = 0;
            end else if (!if_req) begin
                run = 0;
            end
        end else begin
            if (!if_req) run = 0;
            if (!cur.is_data && IF_flush) cur.drop = 1;
            if (m_ready) begin
                cur.busy = 0;
                cur.drop = 0;
            end
        end
    endtask

    task automatic check_outputs();
        bit e_if_ready, e_dm_ready;
        e_if_ready = cur.busy && !cur.is_data && m_ready && !(cur.drop || IF_flush);
        e_dm_ready = cur.busy && cur.is_data && m_ready;
        check("m_valid",   m_valid,   cur.busy);
        check("m_addr",    m_addr,    cur.addr);
        check("m_we",      m_we,      cur.we);
        check("m_wdata",   m_wdata,   cur.wdata);
        check("if_ready",  if_ready,  e_if_ready);
        check("dm_ready",  dm_ready,  e_dm_ready);
        check("if_stall",  if_stall,  if_req && !e_if_ready);
        check("mem_stall", mem_stall, (mem_read || mem_write) && !e_dm_ready);
        if (e_if_ready) check("if_rdata", if_rdata, m_rdata);
        if (e_dm_ready && !cur.we) check("dm_rdata", dm_rdata, m_rdata);
        if (m_valid && !prev_valid) dut_grants.push_back(m_addr);
        prev_valid    = m_valid;
        if_pulses    += int'(if_ready);
        dm_pulses    += int'(dm_ready);
        last_if_ready = if_ready;
        last_dm_ready = dm_ready;
    endtask

    // Called at posedge+1 with inputs already driven for this cycle.
    task automatic tick();
        #1;
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int budget);
        int n = 0;
        while (!m_valid && n < budget) begin
            tick();
            n++;
        end
        check("grant_within_budget", m_valid, 1'b1);
    endtask

    // Memory answers lat cycles after the first m_valid cycle.
    task automatic respond(input int lat, input logic [31:0] data);
        for (int k = 0; k < lat; k++) begin
            m_ready = 1'b0;
            tick();
        end
        m_ready = 1'b1;
        m_rdata = data;
        tick();
        m_ready = 1'b0;
        m_rdata = 32'h0BAD_F00D;
    endtask

    bit mem_active;
    int mem_lat, mem_cnt, base_if, base_dm;

    initial begin
        rst_n = 1'b0; if_req = 0; if_addr = '0; IF_flush = 0;
        mem_read = 0; mem_write = 0; dm_addr = '0; dm_wdata = '0;
        m_ready = 0; m_rdata = '0;
        prev_valid = 0; if_pulses = 0; dm_pulses = 0;
        model_reset();
        @(posedge clk); #1;
        tick();
        tick();

        // Fetch only, first grant on the first edge after release.
        rst_n = 1'b1; if_req = 1; if_addr = 32'h100;
        tick();
        check("first_grant_valid", m_valid, 1'b1);
        check("first_grant_addr", m_addr, 32'h100);
        respond(3, 32'h0050_0093);
        if_req = 0;
        check("fetch_pulse_count", if_pulses, 1);

        // Simultaneous load and fetch: data first, IDLE gap, then fetch.
        dut_grants.delete();
        mem_read = 1; dm_addr = 32'h2000; if_req = 1; if_addr = 32'h104;
        wait_grant(4);
        respond(2, 32'hCAFE_0001);
        mem_read = 0;
        check("idle_gap_after_data", m_valid, 1'b0);
        wait_grant(4);
        respond(1, 32'h0000_0013);
        if_req = 0;
        check("tie_grant_count", dut_grants.size(), 2);
        check("tie_first_addr", dut_grants[0], 32'h2000);
        check("tie_second_addr", dut_grants[1], 32'h104);

        // Flush in cycle 2 of a fetch: memory completes, data discarded.
        base_if = if_pulses;
        if_req = 1; if_addr = 32'h108;
        wait_grant(4);
        check("flush_fetch_addr", m_addr, 32'h108);
        tick();
        IF_flush = 1;
        tick();
        IF_flush = 0; if_addr = 32'h200;
        tick();
        m_ready = 1; m_rdata = 32'h1111_1111;
        tick();
        m_ready = 0;
        check("flushed_no_if_ready", if_pulses, base_if);
        wait_grant(4);
        check("refetch_new_addr", m_addr, 32'h200);
        respond(1, 32'h2222_2222);
        if_req = 0;
        check("refetch_delivered", if_pulses, base_if + 1);

        // Starvation: data held every grant with fetch waiting.
        dut_grants.delete();
        mem_read = 1; dm_addr = 32'h3000; if_req = 1; if_addr = 32'h300;
        for (int g = 0; g < 5; g++) begin
            wait_grant(4);
            respond(1, 32'h3333_0000 + 32'(g));
        end
        mem_read = 0; if_req = 0;
        check("starve_grant_count", dut_grants.size(), 5);
        check("starve_4th_is_data", dut_grants[3], 32'h3000);
        check("starve_5th_is_fetch", dut_grants[4], 32'h300);

        // Store: write request held stable until m_ready.
        base_dm = dm_pulses;
        mem_write = 1; dm_addr = 32'h2004; dm_wdata = 32'hDEAD_BEEF;
        wait_grant(4);
        for (int k = 0; k < 3; k++) begin
            check("store_we_held", m_we, 1'b1);
            check("store_addr_held", m_addr, 32'h2004);
            check("store_wdata_held", m_wdata, 32'hDEAD_BEEF);
            tick();
        end
        m_ready = 1; m_rdata = 32'hFFFF_FFFF;
        tick();
        m_ready = 0; mem_write = 0;
        check("store_one_pulse", dm_pulses, base_dm + 1);
        tick();
        check("store_no_second_pulse", dm_pulses, base_dm + 1);

        // Reset asserted mid-DATA: outputs drop without a clock edge.
        base_dm = dm_pulses;
        mem_read = 1; dm_addr = 32'h2008;
        wait_grant(4);
        tick();
        #2;
        rst_n = 0; m_ready = 1;
        #1;
        check("reset_m_valid_async", m_valid, 1'b0);
        check("reset_dm_ready_async", dm_ready, 1'b0);
        check("reset_m_addr_async", m_addr, 32'h0);
        model_reset();
        prev_valid = m_valid;
        @(posedge clk); #1;
        check("reset_no_pulse", dm_pulses, base_dm);
        mem_read = 0; m_ready = 0; rst_n = 1;
        tick();
        check("idle_after_release", m_valid, 1'b0);

        // Randomized traffic against the model.
        mem_active = 0; mem_lat = 1; mem_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            IF_flush = 0;
            if (last_if_ready) if_req = 0;
            if (!if_req && $urandom_range(2) == 0) begin
                if_req = 1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (last_dm_ready) begin
                mem_read = 0;
                mem_write = 0;
            end
            if (!mem_read && !mem_write && $urandom_range(2) == 0) begin
                if ($urandom_range(1) == 1) mem_write = 1;
                else mem_read = 1;
                dm_addr = $urandom;
                dm_wdata = $urandom;
            end
            if (m_valid && !mem_active) begin
                mem_active = 1;
                mem_lat = $urandom_range(4, 1);
                mem_cnt = 0;
            end
            if (mem_active) m_ready = (mem_cnt == mem_lat);
            else m_ready = ($urandom_range(7) == 0);
            m_rdata = $urandom;
            if (if_req && !m_ready && $urandom_range(9) == 0) IF_flush = 1;
            tick();
            if (IF_flush) if_addr = $urandom & 32'hFFFF_FFFC;
            if (mem_active) begin
                if (m_ready) mem_active = 0;
                else mem_cnt++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_DATA_RUN, default 4, meaning the consecutive data grants allowed while a fetch waits before the fetch takes priority.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 if_req  in  1  fetch request, held until if_ready.
REQ-005 if_addr  in  32  fetch address.
REQ-006 IF_flush  in  1  branch-taken flush, cancels the current fetch.
REQ-007 if_rdata  out  32  fetched instruction, valid with if_ready.
REQ-008 if_ready  out  1  one-cycle fetch completion pulse.
REQ-009 mem_read / mem_write  in  1 each  data request from the control path, held until dm_ready; never both set.
REQ-010 dm_addr / dm_wdata  in  32 each  data address and store data.
REQ-011 dm_rdata  out  32  load data, valid with dm_ready.
REQ-012 dm_ready  out  1  one-cycle data completion pulse.
REQ-013 m_valid, m_we  out  1 each  shared memory request and write enable.
REQ-014 m_addr, m_wdata  out  32 each  memory address and write data.
REQ-015 m_rdata  in  32, m_ready  in  1  memory read data and completion pulse; variable latency of at least 1 cycle.
REQ-016 if_stall, mem_stall  out  1 each  pipeline stall requests.

Function
REQ-017 SHALL use FSM states IDLE, FETCH, DATA.
REQ-018 IDLE: data request pending -> DATA; else if_req && !IF_flush -> FETCH; else stay.
REQ-019 Simultaneous requests SHALL grant data, unless run_cnt == MAX_DATA_RUN, in which case fetch is granted.
REQ-020 run_cnt SHALL increment on each data grant while if_req is high, saturate at MAX_DATA_RUN, and clear on a fetch grant or when if_req is low.
REQ-021 In FETCH/DATA, m_valid SHALL be 1 and m_addr/m_we/m_wdata SHALL be registered at grant and held stable until m_ready.
REQ-022 On m_ready the FSM SHALL return to IDLE; back-to-back grants SHALL need one IDLE cycle between them.
REQ-023 dm_ready SHALL equal m_ready in DATA, and dm_rdata SHALL pass m_rdata combinationally; stores return dm_ready with dm_rdata ignored.
REQ-024 if_ready SHALL equal m_ready in FETCH && !drop, where drop is a flag set when IF_flush is seen in FETCH and cleared when leaving FETCH.
REQ-025 A flushed fetch SHALL complete on the memory side (no abort) and its data SHALL be discarded.
REQ-026 if_stall SHALL equal if_req && !if_ready; mem_stall SHALL equal (mem_read|mem_write) && !dm_ready; both are combinational.
REQ-027 m_ready outside FETCH/DATA SHALL be ignored.
REQ-028 Reset mid-transaction SHALL drop the transaction and issue no ready pulse.

Reset
REQ-029 While rst_n=0: state=IDLE, m_valid=0, m_we=0, m_addr=0, m_wdata=0, run_cnt=0, drop=0, if_ready=0, dm_ready=0, effective immediately.
REQ-030 The first grant SHALL be possible on the first rising edge after rst_n goes high.

Structure
REQ-031 The state enum and the default MAX_DATA_RUN SHALL live in a shared pipeline package alongside the opcode constants.
REQ-032 SHALL be a single module, with an optional sub-module arb_prio computing the grant from the requests and run_cnt.

Verification
REQ-033 Fetch only: if_addr=0x100, m_ready 3 cycles after m_valid, m_rdata=0x00500093 -> if_ready is one pulse with that data, and if_stall is high until then.
REQ-034 Simultaneous lw (0x2000) and fetch (0x104) -> data is granted first, then fetch after one IDLE cycle, with m_addr sequence 0x2000 then 0x104.
REQ-035 Flush: IF_flush in cycle 2 of a fetch at 0x108 -> memory completes, if_ready stays 0, and the next fetch is at the new if_addr.
REQ-036 Starvation: data requests every grant with if_req held, MAX_DATA_RUN=4 -> the 5th grant is the fetch.
REQ-037 Store: sw with dm_addr=0x2004, dm_wdata=0xDEADBEEF -> m_we=1 with those values held until m_ready, and dm_ready is one pulse.
REQ-038 Reset asserted while in DATA -> m_valid falls without waiting for a clock edge, no dm_ready pulse, and state is IDLE after release.
